// File: rtl/io_timer_bank_pkg.sv
// Shared register map, CTRL bit positions and byte-merge helper for the io_timer_bank peripheral.
package io_timer_bank_pkg;

  localparam int unsigned OFF_PRESCALE = 0;
  localparam int unsigned OFF_TICKS    = 1;
  localparam int unsigned CH_BASE      = 4;
  localparam int unsigned CH_STRIDE    = 4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_CAP_IE   = 3;
  localparam int CTRL_MATCH    = 8;
  localparam int CTRL_CAPF     = 9;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_LOAD    = 2'd1,
    REG_COUNT   = 2'd2,
    REG_CAPTURE = 2'd3
  } ch_reg_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wmask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = wmask[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/io_timer_bank_channel.sv
// One timer channel: CTRL/LOAD/COUNT/CAPTURE registers plus tick-driven down-count and expiry.
// Capture logic exists only when TIMER_BANK_CAPTURE_EN is defined.
module io_timer_bank_channel
  import io_timer_bank_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr_en,
  input  ch_reg_e     reg_sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        irq_req
`ifdef TIMER_BANK_CAPTURE_EN
  ,
  input  logic        cap_in
`endif
);

  logic                 en, periodic, ie, match;
  logic                 cap_ie, capf;
  logic [CNT_WIDTH-1:0] load, count, capture;
  logic                 en_n, match_set;
  logic [CNT_WIDTH-1:0] count_n;
  logic                 ctrl_we, load_we, count_we, ctrl_lo_we, ctrl_w1c;

  assign ctrl_we    = wr_en && (reg_sel == REG_CTRL);
  assign load_we    = wr_en && (reg_sel == REG_LOAD);
  assign count_we   = wr_en && (reg_sel == REG_COUNT);
  assign ctrl_lo_we = ctrl_we && wmask[0];
  assign ctrl_w1c   = ctrl_we && wmask[1];

  // Expiry is evaluated on the old EN; a same-cycle CTRL or COUNT write then takes priority.
  always_comb begin
    en_n      = en;
    count_n   = count;
    match_set = 1'b0;
    if (tick && en) begin
      if (count == '0) begin
        match_set = 1'b1;
        if (periodic) count_n = load;
        else          en_n    = 1'b0;
      end else begin
        count_n = count - 1'b1;
      end
    end
    if (ctrl_lo_we) begin
      en_n = wdata[CTRL_EN];
      if (wdata[CTRL_EN] && !en) count_n = load;
    end
    if (count_we) count_n = CNT_WIDTH'(merge_bytes(32'(count), wdata, wmask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      match    <= 1'b0;
      load     <= '0;
      count    <= '0;
    end else begin
      en    <= en_n;
      count <= count_n;
      if (ctrl_lo_we) begin
        periodic <= wdata[CTRL_PERIODIC];
        ie       <= wdata[CTRL_IE];
      end
      if (load_we) load <= CNT_WIDTH'(merge_bytes(32'(load), wdata, wmask));
      match <= (match && !(ctrl_w1c && wdata[CTRL_MATCH])) || match_set;
    end
  end

`ifdef TIMER_BANK_CAPTURE_EN
  logic cap_q, cap_rise;
  assign cap_rise = cap_in && !cap_q;

  // Capture samples the register value before any same-cycle COUNT write or decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q   <= 1'b0;
      cap_ie  <= 1'b0;
      capf    <= 1'b0;
      capture <= '0;
    end else begin
      cap_q <= cap_in;
      if (cap_rise) capture <= count;
      if (ctrl_lo_we) cap_ie <= wdata[CTRL_CAP_IE];
      capf <= (capf && !(ctrl_w1c && wdata[CTRL_CAPF])) || cap_rise;
    end
  end
`else
  assign cap_ie  = 1'b0;
  assign capf    = 1'b0;
  assign capture = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:    rdata = {22'b0, capf, match, 4'b0, cap_ie, ie, periodic, en};
      REG_LOAD:    rdata = 32'(load);
      REG_COUNT:   rdata = 32'(count);
      REG_CAPTURE: rdata = 32'(capture);
      default:     rdata = '0;
    endcase
  end

  assign irq_req = (match && ie) || (capf && cap_ie);

endmodule

// File: rtl/io_timer_bank.sv
// Memory-mapped timer bank: shared prescaler, TICKS counter, NUM_CH channels, registered read and irq.
// Optional capture inputs are enabled by defining TIMER_BANK_CAPTURE_EN.
module io_timer_bank
  import io_timer_bank_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        irq
`ifdef TIMER_BANK_CAPTURE_EN
  ,
  input  logic [NUM_CH-1:0] cap_in
`endif
);

  logic [5:0]           word;
  logic                 wr, rd, pre_we, tick;
  logic [PRE_WIDTH-1:0] pre_reg, pre_cnt;
  logic [CNT_WIDTH-1:0] ticks;
  logic [31:0]          rd_val;
  logic [31:0]          ch_rd [NUM_CH];
  logic [NUM_CH-1:0]    ch_irq;
  logic                 unused_addr;

  assign word        = mem_addr[7:2];
  assign unused_addr = ^{mem_addr[31:8], mem_addr[1:0]};
  assign wr          = sel && (mem_wmask != 4'b0);
  assign rd          = sel && mem_rstrb;
  assign pre_we      = wr && (word == 6'(OFF_PRESCALE));
  // A PRESCALE write restarts the prescaler and suppresses that cycle's tick.
  assign tick        = (pre_cnt == pre_reg) && !pre_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg <= '0;
      pre_cnt <= '0;
      ticks   <= '0;
    end else begin
      if (pre_we) begin
        pre_reg <= PRE_WIDTH'(merge_bytes(32'(pre_reg), mem_wdata, mem_wmask));
        pre_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (tick) ticks <= ticks + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_hit;
    assign ch_hit = (word[5:2] == 4'(CH_BASE / CH_STRIDE + i));

    io_timer_bank_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr_en   (wr && ch_hit),
      .reg_sel (ch_reg_e'(word[1:0])),
      .wdata   (mem_wdata),
      .wmask   (mem_wmask),
      .rdata   (ch_rd[i]),
      .irq_req (ch_irq[i])
`ifdef TIMER_BANK_CAPTURE_EN
      ,
      .cap_in  (cap_in[i])
`endif
    );
  end

  always_comb begin
    rd_val = '0;
    if (word == 6'(OFF_PRESCALE))   rd_val = 32'(pre_reg);
    else if (word == 6'(OFF_TICKS)) rd_val = 32'(ticks);
    for (int i = 0; i < NUM_CH; i++)
      if (word[5:2] == 4'(CH_BASE / CH_STRIDE + i)) rd_val = ch_rd[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (rd) mem_rdata <= rd_val;
      irq <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_io_timer_bank.sv
// Scoreboard bench for io_timer_bank: directed register scenarios, then randomized bus traffic,
// checked against a cycle-level behavioural model of the register map and timer rules.
module tb_io_timer_bank;

  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 32;
  localparam int PRE_WIDTH = 16;
`ifdef TIMER_BANK_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif
  localparam logic [31:0] CNT_MASK = 32'((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [31:0] PRE_MASK = 32'((64'd1 << PRE_WIDTH) - 64'd1);

  logic        clk, reset, sel, mem_rstrb, irq;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [NUM_CH-1:0] cap_cur;
`ifdef TIMER_BANK_CAPTURE_EN
  logic [NUM_CH-1:0] cap_in;
`endif

  io_timer_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .irq       (irq)
`ifdef TIMER_BANK_CAPTURE_EN
    ,
    .cap_in    (cap_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_q [$];
  bit          irq_q [$];

  // Reference model state
  logic [31:0] m_pre, m_pre_cnt, m_ticks;
  bit          m_en [NUM_CH], m_per [NUM_CH], m_ie [NUM_CH], m_capie [NUM_CH];
  bit          m_match [NUM_CH], m_capf [NUM_CH], m_cap_prev [NUM_CH];
  logic [31:0] m_load [NUM_CH], m_count [NUM_CH], m_capt [NUM_CH];

  function automatic logic [31:0] bytes_of(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    int c, sub;
    if (w == 0) return m_pre;
    if (w == 1) return m_ticks;
    if (w < 4) return 32'h0;
    c   = (w - 4) / 4;
    sub = (w - 4) % 4;
    if (c >= NUM_CH) return 32'h0;
    case (sub)
      0: return {22'b0, m_capf[c], m_match[c], 4'b0, m_capie[c], m_ie[c], m_per[c], m_en[c]};
      1: return m_load[c];
      2: return m_count[c];
      default: return m_capt[c];
    endcase
  endfunction

  task automatic model_reset();
    m_pre = '0; m_pre_cnt = '0; m_ticks = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_capie[c] = 0;
      m_match[c] = 0; m_capf[c] = 0; m_cap_prev[c] = 0;
      m_load[c] = '0; m_count[c] = '0; m_capt[c] = '0;
    end
  endtask

  task automatic model_cycle(input bit s, input bit rs, input int w, input logic [31:0] d,
                             input logic [3:0] m, input bit r, input logic [NUM_CH-1:0] cp);
    bit          wr, tick, irq_next;
    logic [31:0] bm;
    if (rs) begin
      model_reset();
      irq_q.push_back(1'b0);
      return;
    end
    if (s && r) rd_q.push_back(model_read(w));
    irq_next = 0;
    for (int c = 0; c < NUM_CH; c++)
      irq_next |= (m_match[c] && m_ie[c]) || (m_capf[c] && m_capie[c]);
    irq_q.push_back(irq_next);

    wr   = s && (m != 4'b0);
    bm   = bytes_of(m);
    tick = !(wr && w == 0) && (m_pre_cnt == m_pre);
    if (wr && w == 0) begin
      m_pre     = ((m_pre & ~bm) | (d & bm)) & PRE_MASK;
      m_pre_cnt = 0;
    end else if (tick) m_pre_cnt = 0;
    else m_pre_cnt = m_pre_cnt + 1;
    if (tick) m_ticks = (m_ticks + 1) & CNT_MASK;

    for (int c = 0; c < NUM_CH; c++) begin
      logic [31:0] old_count;
      bit old_en, set_m, set_c, clr_m, clr_c, hit;
      int sub;
      old_count = m_count[c];
      old_en    = m_en[c];
      set_m = 0; set_c = 0; clr_m = 0; clr_c = 0;
      hit = wr && (w >= 4) && ((w - 4) / 4 == c);
      sub = (w - 4) % 4;
      if (tick && old_en) begin
        if (old_count == 0) begin
          set_m = 1;
          if (m_per[c]) m_count[c] = m_load[c];
          else m_en[c] = 0;
        end else m_count[c] = (old_count - 1) & CNT_MASK;
      end
      if (CAP_EN && cp[c] && !m_cap_prev[c]) begin
        m_capt[c] = old_count;
        set_c = 1;
      end
      m_cap_prev[c] = cp[c];
      if (hit) begin
        case (sub)
          0: begin
            if (m[0]) begin
              if (d[0] && !old_en) m_count[c] = m_load[c];
              m_en[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2];
              if (CAP_EN) m_capie[c] = d[3];
            end
            if (m[1]) begin clr_m = d[8]; clr_c = d[9]; end
          end
          1: m_load[c]  = ((m_load[c] & ~bm) | (d & bm)) & CNT_MASK;
          2: m_count[c] = ((old_count & ~bm) | (d & bm)) & CNT_MASK;
          default: ;
        endcase
      end
      m_match[c] = (m_match[c] && !clr_m) || set_m;
      m_capf[c]  = (m_capf[c] && !clr_c) || set_c;
    end
  endtask

  // Apply one bus cycle: drive pins, advance the model, wait past the edge.
  task automatic drive(input bit s, input bit rs, input logic [5:0] w, input logic [31:0] d,
                       input logic [3:0] m, input bit r);
    logic [31:0] hi;
    hi        = $urandom;
    sel       = s;
    reset     = rs;
    mem_addr  = {hi[23:0], w, hi[25:24]};
    mem_rstrb = r;
    mem_wdata = d;
    mem_wmask = m;
`ifdef TIMER_BANK_CAPTURE_EN
    cap_in = cap_cur;
`endif
    model_cycle(s, rs, int'(w), d, m, r, cap_cur);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] w, input logic [31:0] d, input logic [3:0] m);
    drive(1'b1, 1'b0, w, d, m, 1'b0);
  endtask

  task automatic bus_rd(input logic [5:0] w);
    drive(1'b1, 1'b0, w, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
  endtask

  // Monitor: compares irq every cycle and mem_rdata (fresh after a read, held otherwise).
  initial begin : monitor
    logic [31:0] last_exp;
    bit          rd_f, rst_f, expi;
    last_exp = '0;
    forever begin
      @(posedge clk);
      rd_f  = sel && mem_rstrb && !reset;
      rst_f = reset;
      @(negedge clk);
      if (irq_q.size() > 0) begin
        expi = irq_q.pop_front();
        n_vec++;
        if (irq !== expi) begin
          n_err++;
          $display("FAIL irq t=%0t: got %b expected %b", $time, irq, expi);
        end
      end
      if (rst_f) last_exp = '0;
      else if (rd_f) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rdata t=%0t: read with no expected value", $time);
        end else last_exp = rd_q.pop_front();
      end
      n_vec++;
      if (mem_rdata !== last_exp) begin
        n_err++;
        $display("FAIL rdata t=%0t: got %h expected %h", $time, mem_rdata, last_exp);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    cap_cur = '0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 6'd0, 32'h0, 4'h0, 1'b0);
    for (int w = 0; w < 24; w++) bus_rd(6'(w));

    // Periodic ch0: PRESCALE=3, LOAD=4 -> expiry every 20 cycles
    bus_wr(6'd0, 32'd3, 4'hF);
    bus_wr(6'd5, 32'd4, 4'hF);
    bus_wr(6'd4, 32'h7, 4'hF);
    for (int k = 0; k < 45; k++) begin
      if (k == 19) bus_rd(6'd1);
      else if (k == 21 || k == 41) bus_rd(6'd4);
      else idle(1);
    end
    bus_wr(6'd4, 32'h0, 4'hF);
    bus_wr(6'd4, 32'h100, 4'h2);
    idle(2);

    // One-shot ch1: PRESCALE=0, LOAD=2
    bus_wr(6'd0, 32'd0, 4'hF);
    bus_wr(6'd9, 32'd2, 4'hF);
    bus_wr(6'd8, 32'h1, 4'hF);
    idle(2);
    bus_rd(6'd10);
    idle(2);
    bus_rd(6'd8);
    bus_rd(6'd10);
    idle(3);
    bus_rd(6'd10);

    // ch0 LOAD=0 periodic: every tick is an expiry, so a w1c there cannot clear MATCH
    bus_wr(6'd5, 32'd0, 4'hF);
    bus_wr(6'd4, 32'h7, 4'hF);
    bus_wr(6'd4, 32'h107, 4'hF);
    bus_rd(6'd4);
    bus_wr(6'd4, 32'h100, 4'hF);
    bus_rd(6'd4);
    bus_wr(6'd4, 32'h100, 4'hF);
    bus_rd(6'd4);
    idle(3);

    // Byte-lane write into LOAD0
    bus_wr(6'd5, 32'h11223344, 4'hF);
    bus_wr(6'd5, 32'h0000AB00, 4'b0010);
    bus_rd(6'd5);

`ifdef TIMER_BANK_CAPTURE_EN
    bus_wr(6'd13, 32'd100, 4'hF);
    bus_wr(6'd12, 32'hB, 4'hF);
    idle(4);
    cap_cur[2] = 1'b1;
    idle(2);
    cap_cur[2] = 1'b0;
    bus_rd(6'd15);
    bus_rd(6'd12);
    idle(2);
`endif

    // Reset in the middle of activity
    bus_wr(6'd4, 32'h7, 4'hF);
    idle(3);
    drive(1'b1, 1'b1, 6'd4, 32'h0, 4'h0, 1'b1);
    bus_rd(6'd4);

    for (int k = 0; k < 700; k++) begin
      int          kind;
      logic [5:0]  w;
      logic [31:0] d;
      logic [3:0]  m;
      bit          r, s, rs;
      kind = $urandom_range(0, 9);
      w = (kind == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 23));
      if (w == 6'd0) d = $urandom_range(0, 3);
      else if (w >= 6'd4 && w[1:0] == 2'd0) d = $urandom & 32'h30F;
      else if (w >= 6'd4 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 6);
      else d = $urandom;
      m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 2) != 0) m = 4'h0;
      r  = ($urandom_range(0, 2) == 0);
      s  = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) cap_cur = NUM_CH'($urandom);
      drive(s, rs, w, d, m, r);
    end
    idle(2);

    @(negedge clk);
    #1;
    n_vec++;
    if (rd_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d reads left unanswered, expected 0", rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
